ins_mem_fetch: RTL and testbench

Parametrised instruction memory with a registered, handshaked fetch port and a streaming program-load port. It replaces the purely combinational instruction store: the controller fetches through a req/valid handshake with one-cycle latency, and a loader rewrites any address window at run time without re-synthesis. It sits between the PC/fetch logic and the instruction register.

---
 rtl/ins_mem_fetch.sv | 102 ++++++++++
 tb/tb_ins_mem_fetch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ins_mem_fetch.sv
// ins_mem_fetch: instruction memory with a registered req/valid fetch port and a streaming program-load port
// Ports: clk, rst (async, active high); fetch_req/fetch_addr -> ins/ins_valid one cycle later, fetch_ready high in IDLE;
// load_start/load_base/load_len open a load window, load_valid/load_data stream words into it,
// load_busy/load_done/load_count report load progress.
module ins_mem_fetch #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter bit INIT_PROG = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ready,
  output logic [DW-1:0] ins,
  output logic          ins_valid,
  input  logic          load_start,
  input  logic [AW-1:0] load_base,
  input  logic [AW:0]   load_len,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_busy,
  output logic          load_done,
  output logic [AW:0]   load_count
);
  typedef enum logic {IDLE, LOAD} state_t;
  function automatic logic [DW-1:0] prog_word(input logic [15:0] w);
    return INIT_PROG ? DW'(w) : '0;
  endfunction
  // Power-up image only; rst never touches the array so loaded programs survive a reset.
  logic [DW-1:0] mem [2**AW] = '{
    0: prog_word(16'h7000), 1: prog_word(16'h1000), 2: prog_word(16'h2000),
    3: prog_word(16'h3000), 5: prog_word(16'h5001), 6: prog_word(16'h6002),
    7: prog_word(16'h8009), 9: prog_word(16'h9002), 11: prog_word(16'h4000),
    default: '0
  };
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DW-1:0] ins_q, ins_d;
  logic          ins_valid_q, ins_valid_d, load_done_q, load_done_d, we;
  assign cnt_inc = cnt_q + 1'b1;
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ins_d       = ins_q;
    ins_valid_d = 1'b0;
    load_done_d = 1'b0;
    we          = 1'b0;
    if (state_q == IDLE) begin
      if (fetch_req) begin
        ins_d       = mem[fetch_addr];
        ins_valid_d = 1'b1;
      end
      if (load_start && load_len != '0) begin
        state_d = LOAD;
        ptr_d   = load_base;
        len_d   = load_len;
        cnt_d   = '0;
      end
    end else if (load_valid) begin
      we    = 1'b1;
      ptr_d = ptr_q + 1'b1;
      cnt_d = cnt_inc;
      if (cnt_inc == len_q) begin
        state_d     = IDLE;
        load_done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      load_done_q <= load_done_d;
    end
  end
  // we is qualified by state_q, which rst forces to IDLE, so no write happens while in reset.
  always_ff @(posedge clk) begin
    if (we) mem[ptr_q] <= load_data;
  end
  assign load_busy   = state_q == LOAD;
  assign fetch_ready = ~load_busy;
  assign ins         = ins_q;
  assign ins_valid   = ins_valid_q;
  assign load_done   = load_done_q;
  assign load_count  = cnt_q;
endmodule

// File: tb/tb_ins_mem_fetch.sv
// tb_ins_mem_fetch: directed self-checking bench for ins_mem_fetch
module tb_ins_mem_fetch;
  logic        clk = 1'b0, rst, fetch_req = 1'b0, load_start = 1'b0, load_valid = 1'b0;
  logic [11:0] fetch_addr = '0, load_base = '0;
  logic [12:0] load_len = '0, load_count;
  logic [15:0] load_data = '0, ins;
  logic        fetch_ready, ins_valid, load_busy, load_done;
  int          checks = 0, failures = 0, busy_n = 0, dones = 0;
  always #5 clk = ~clk;
  ins_mem_fetch dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .ins(ins), .ins_valid(ins_valid),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data),
    .load_busy(load_busy), .load_done(load_done), .load_count(load_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [11:0] a, input logic [15:0] e);
    fetch_req = 1'b1;
    fetch_addr = a;
    tick();
    check($sformatf("ins@%0h", a), ins, e);
    check($sformatf("ins_valid@%0h", a), ins_valid, 1);
  endtask
  task automatic start_load(input logic [11:0] b, input logic [12:0] n);
    load_start = 1'b1;
    load_base = b;
    load_len = n;
    tick();
    load_start = 1'b0;
  endtask
  task automatic write(input logic [15:0] d);
    load_valid = 1'b1;
    load_data = d;
    tick();
    load_valid = 1'b0;
  endtask
  task automatic acc();
    busy_n += int'(load_busy);
    dones += int'(load_done);
  endtask
  initial begin
    rst = 1'b1;
    tick();
    tick();
    check("rst_ins", ins, 0);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_load_busy", load_busy, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_count", load_count, 0);
    rst = 1'b0;
    tick();
    fetch(12'h000, 16'h7000);
    fetch(12'h005, 16'h5001);
    fetch(12'h007, 16'h8009);
    fetch(12'h00B, 16'h4000);
    fetch(12'h008, 16'h0000);
    fetch(12'h009, 16'h9002);
    fetch_req = 1'b0;
    tick();
    check("idle_valid", ins_valid, 0);
    check("idle_ins_hold", ins, 16'h9002);
    start_load(12'h020, 13'd3);
    check("a_busy", load_busy, 1);
    check("a_ready", fetch_ready, 0);
    check("a_count0", load_count, 0);
    acc();
    write(16'hA001);
    acc();
    tick();
    acc();
    write(16'hA002);
    acc();
    write(16'hA003);
    acc();
    check("a_done", load_done, 1);
    check("a_ready_done", fetch_ready, 1);
    fetch(12'h020, 16'hA001);
    acc();
    check("a_busy_cycles", busy_n, 4);
    check("a_done_pulses", dones, 1);
    check("a_count", load_count, 3);
    fetch(12'h021, 16'hA002);
    fetch(12'h022, 16'hA003);
    fetch_addr = 12'h005;
    start_load(12'hFFF, 13'd2);
    check("sim_ins", ins, 16'h5001);
    check("sim_valid", ins_valid, 1);
    check("sim_busy", load_busy, 1);
    write(16'h1111);
    check("ld_ready", fetch_ready, 0);
    check("ld_valid", ins_valid, 0);
    check("ld_ins_hold", ins, 16'h5001);
    write(16'h2222);
    check("w_done", load_done, 1);
    check("w_valid", ins_valid, 0);
    check("w_count", load_count, 2);
    fetch(12'hFFF, 16'h1111);
    fetch(12'h000, 16'h2222);
    fetch_req = 1'b0;
    start_load(12'h300, 13'd0);
    check("z_busy", load_busy, 0);
    check("z_done", load_done, 0);
    check("z_count", load_count, 2);
    tick();
    check("z_done2", load_done, 0);
    start_load(12'h100, 13'd2);
    load_start = 1'b1;
    load_base = 12'h200;
    load_len = 13'd5;
    write(16'hBBB1);
    load_start = 1'b0;
    check("s_count", load_count, 1);
    check("s_busy", load_busy, 1);
    write(16'hBBB2);
    check("s_done", load_done, 1);
    check("s_count2", load_count, 2);
    fetch(12'h200, 16'h0000);
    fetch(12'h100, 16'hBBB1);
    fetch(12'h101, 16'hBBB2);
    fetch_req = 1'b0;
    start_load(12'h030, 13'd4);
    write(16'hC001);
    write(16'hC002);
    check("r_count_pre", load_count, 2);
    load_valid = 1'b1;
    load_data = 16'hC003;
    #2 rst = 1'b1;
    #1;
    check("r_busy", load_busy, 0);
    check("r_ready", fetch_ready, 1);
    check("r_ins", ins, 0);
    check("r_valid", ins_valid, 0);
    check("r_count", load_count, 0);
    check("r_done", load_done, 0);
    tick();
    rst = 1'b0;
    load_valid = 1'b0;
    tick();
    fetch(12'h030, 16'hC001);
    fetch(12'h031, 16'hC002);
    fetch(12'h032, 16'h0000);
    fetch(12'h033, 16'h0000);
    fetch_req = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
